// File: rtl/line_write_buffer.sv
// Posted write buffer: queues 256-bit dirty-line evictions and drains them to memory in the background.
// Fill reads take priority over draining; define WB_FWD_EN to forward hazard reads from the buffer.
module line_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           c_wr_valid,
    output logic           c_wr_ready,
    input  logic [31:0]    c_wr_addr,
    input  logic [255:0]   c_wr_data,
    input  logic           c_rd_req,
    output logic           c_rd_ready,
    input  logic [31:0]    c_rd_addr,
    output logic [255:0]   c_rd_data,
    output logic           c_rd_done,
    output logic [31:0]    m_addr,
    output logic [255:0]   m_wdata,
    output logic           m_read,
    output logic           m_write,
    input  logic [255:0]   m_rdata,
    input  logic           m_ready,
    output logic           wb_empty,
    output logic [PTR_W:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    state_t state, state_nx;

    logic [31:0]      addr_mem [DEPTH];
    logic [255:0]     data_mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;

    logic             rd_pend;
    logic [31:0]      rd_addr;

    logic             push, pop, rd_accept;
    logic             hazard;
    logic [255:0]     fwd_data;
    logic             start_rd, start_wr, fwd_done;

    // Line offset bits are dropped on both address paths.
    logic             unused_lsbs;
    assign unused_lsbs = ^{c_wr_addr[4:0], c_rd_addr[4:0]};

    assign c_wr_ready = (count < (PTR_W+1)'(DEPTH));
    assign c_rd_ready = !rd_pend;
    assign wb_empty   = (count == '0);
    assign wb_count   = count;

    assign push      = c_wr_valid && c_wr_ready;
    assign pop       = (state == WR_WAIT) && m_ready;
    assign rd_accept = c_rd_req && c_rd_ready;

    // Walk entries oldest to youngest so the last match is the youngest copy.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hazard   = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (addr_mem[idx] == rd_addr)) begin
                hazard   = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end

    always_comb begin
        state_nx = state;
        start_rd = 1'b0;
        start_wr = 1'b0;
        fwd_done = 1'b0;
        case (state)
            IDLE: begin
                if (rd_pend && !hazard) begin
                    start_rd = 1'b1;
                    state_nx = RD_WAIT;
                end
`ifdef WB_FWD_EN
                else if (rd_pend && hazard) begin
                    fwd_done = 1'b1;
                end
`endif
                // Without forwarding a hazard read lands here and drains the head.
                else if (count != '0) begin
                    start_wr = 1'b1;
                    state_nx = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (m_ready) state_nx = IDLE;
            end
            WR_WAIT: begin
                if (m_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= {c_wr_addr[31:5], 5'b0};
            data_mem[tail] <= c_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
        end else if (rd_accept) begin
            rd_pend <= 1'b1;
            rd_addr <= {c_rd_addr[31:5], 5'b0};
        end else if (((state == RD_WAIT) && m_ready) || fwd_done) begin
            rd_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            c_rd_done <= 1'b0;
            c_rd_data <= '0;
        end else begin
            m_read    <= start_rd;
            m_write   <= start_wr;
            c_rd_done <= ((state == RD_WAIT) && m_ready) || fwd_done;
            if (start_rd) m_addr <= rd_addr;
            if (start_wr) begin
                m_addr  <= addr_mem[head];
                m_wdata <= data_mem[head];
            end
            if ((state == RD_WAIT) && m_ready) c_rd_data <= m_rdata;
            else if (fwd_done)                 c_rd_data <= fwd_data;
        end
    end

endmodule

// File: tb/tb_line_write_buffer.sv
// Self-checking bench for line_write_buffer: cycle vector table plus directed read/reset sequences
// against a fixed-latency memory responder.
module tb_line_write_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           c_wr_valid = 1'b0;
    logic           c_wr_ready;
    logic [31:0]    c_wr_addr = '0;
    logic [255:0]   c_wr_data = '0;
    logic           c_rd_req = 1'b0;
    logic           c_rd_ready;
    logic [31:0]    c_rd_addr = '0;
    logic [255:0]   c_rd_data;
    logic           c_rd_done;
    logic [31:0]    m_addr;
    logic [255:0]   m_wdata;
    logic           m_read;
    logic           m_write;
    logic [255:0]   m_rdata = '0;
    logic           m_ready = 1'b0;
    logic           wb_empty;
    logic [PTR_W:0] wb_count;

    line_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_wr_valid(c_wr_valid), .c_wr_ready(c_wr_ready),
        .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .c_rd_req(c_rd_req), .c_rd_ready(c_rd_ready), .c_rd_addr(c_rd_addr),
        .c_rd_data(c_rd_data), .c_rd_done(c_rd_done),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .wb_empty(wb_empty), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] wdata_of(input logic [31:0] a);
        return {8{a ^ 32'hDEAD_0000}};
    endfunction

    function automatic logic [255:0] rdata_of(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } op_t;

    op_t         log_q[$];
    int          lat = 10;
    int          cnt = 0;
    bit          busy = 1'b0;
    logic [31:0] op_addr = '0;

    // Memory model: m_ready arrives lat cycles after the issue pulse; keeps counting through reset.
    initial forever begin
        @(negedge clk);
        if (m_ready) m_ready = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                m_ready = 1'b1;
                m_rdata = rdata_of(op_addr);
                busy    = 1'b0;
            end
        end
        if (m_read || m_write) begin
            check("m_overlap", busy, 0);
            check("m_addr_align", m_addr[4:0], 0);
            log_q.push_back('{wr: m_write, addr: m_addr, data: m_wdata});
            busy    = 1'b1;
            cnt     = lat;
            op_addr = m_addr;
        end
    end

    typedef struct {
        logic           wr_valid;
        logic [31:0]    wr_addr;
        logic [PTR_W:0] e_count;
        logic           e_wr_ready;
        logic           e_rd_ready;
        logic           e_m_write;
        logic           e_m_read;
        logic           e_rd_done;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [31:0] a, input int c,
                                input logic wrr, input logic mw);
        vec_t r;
        r.wr_valid   = v;
        r.wr_addr    = a;
        r.e_count    = (PTR_W+1)'(c);
        r.e_wr_ready = wrr;
        r.e_rd_ready = 1'b1;
        r.e_m_write  = mw;
        r.e_m_read   = 1'b0;
        r.e_rd_done  = 1'b0;
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        c_wr_valid = 1'b0;
        c_rd_req   = 1'b0;
        while (!(wb_empty && c_rd_ready && !busy && !m_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 400, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, output int done_at, output logic [255:0] data);
        c_rd_req  = 1'b1;
        c_rd_addr = a;
        done_at   = -1;
        data      = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                c_rd_req   = 1'b0;
                c_wr_valid = 1'b0;
                check("rd_ready_low", c_rd_ready, 0);
            end
            if (c_rd_done) begin
                done_at = k;
                data    = c_rd_data;
                break;
            end
        end
        check("rd_done_seen", done_at > 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t         vecs[15];
    int           done_at;
    logic [255:0] rdat;
    int           n0;

    initial begin
        vecs[0]  = mk(1'b1, 32'h000, 0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b1, 32'h020, 1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 32'h040, 2, 1'b1, 1'b1);
        vecs[3]  = mk(1'b1, 32'h060, 3, 1'b1, 1'b0);
        for (int i = 4; i <= 12; i++) vecs[i] = mk(1'b1, 32'h080, 4, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 32'h000, 3, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 32'h000, 3, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("rst_wb_empty", wb_empty, 1);
        check("rst_m_addr", m_addr, 0);
        check("rst_rd_data", c_rd_data, 0);
        check("rst_m_read", m_read, 0);
        rst_n = 1'b1;

        // Fill to full with a refused push held through the first pop cycle.
        lat = 10;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_count", i),    wb_count,   vecs[i].e_count);
            check($sformatf("vec%0d_wr_ready", i), c_wr_ready, vecs[i].e_wr_ready);
            check($sformatf("vec%0d_rd_ready", i), c_rd_ready, vecs[i].e_rd_ready);
            check($sformatf("vec%0d_m_write", i),  m_write,    vecs[i].e_m_write);
            check($sformatf("vec%0d_m_read", i),   m_read,     vecs[i].e_m_read);
            check($sformatf("vec%0d_rd_done", i),  c_rd_done,  vecs[i].e_rd_done);
            c_wr_valid = vecs[i].wr_valid;
            c_wr_addr  = vecs[i].wr_addr;
            c_wr_data  = wdata_of(vecs[i].wr_addr);
        end
        wait_idle();
        check("fill_log_size", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check($sformatf("fill_op%0d_wr", i),   log_q[i].wr,   1);
            check($sformatf("fill_op%0d_addr", i), log_q[i].addr, 32'(i * 32));
            check($sformatf("fill_op%0d_data", i), log_q[i].data, wdata_of(32'(i * 32)));
        end

        // Read on an empty buffer; unaligned request address.
        lat = 3;
        log_q.delete();
        do_read(32'h0000_020F, done_at, rdat);
        check("rd_empty_latency", done_at, 6);
        check("rd_empty_data", rdat, rdata_of(32'h200));
        @(negedge clk);
        check("rd_done_one_cycle", c_rd_done, 0);
        wait_idle();
        check("rd_empty_log_size", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check("rd_empty_op_wr", log_q[0].wr, 0);
            check("rd_empty_op_addr", log_q[0].addr, 32'h200);
        end

        // Read arriving during WR_WAIT goes ahead of the next drain.
        lat = 5;
        log_q.delete();
        c_wr_valid = 1'b1; c_wr_addr = 32'h000; c_wr_data = wdata_of(32'h000);
        @(negedge clk);
        c_wr_addr = 32'h020; c_wr_data = wdata_of(32'h020);
        @(negedge clk);
        c_wr_valid = 1'b0;
        @(negedge clk);
        do_read(32'h300, done_at, rdat);
        check("rd_mid_latency", done_at, 12);
        check("rd_mid_data", rdat, rdata_of(32'h300));
        wait_idle();
        check("order_log_size", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            check("order0_wr", log_q[0].wr, 1);
            check("order0_addr", log_q[0].addr, 32'h000);
            check("order1_wr", log_q[1].wr, 0);
            check("order1_addr", log_q[1].addr, 32'h300);
            check("order2_wr", log_q[2].wr, 1);
            check("order2_addr", log_q[2].addr, 32'h020);
        end

        // Hazard: entry pushed in the same cycle as the read request.
        lat = 3;
        log_q.delete();
        c_wr_valid = 1'b1; c_wr_addr = 32'h100; c_wr_data = wdata_of(32'h100);
        do_read(32'h100, done_at, rdat);
`ifdef WB_FWD_EN
        check("haz_latency", done_at, 2);
        check("haz_data", rdat, wdata_of(32'h100));
`else
        check("haz_latency", done_at, 11);
        check("haz_data", rdat, rdata_of(32'h100));
`endif
        wait_idle();
`ifdef WB_FWD_EN
        check("haz_log_size", log_q.size(), 1);
`else
        check("haz_log_size", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("haz_op1_wr", log_q[1].wr, 0);
            check("haz_op1_addr", log_q[1].addr, 32'h100);
        end
`endif
        if (log_q.size() >= 1) begin
            check("haz_op0_wr", log_q[0].wr, 1);
            check("haz_op0_addr", log_q[0].addr, 32'h100);
        end

        // Reset during WR_WAIT with three entries; the late m_ready must be ignored.
        lat = 20;
        log_q.delete();
        c_wr_valid = 1'b1; c_wr_addr = 32'h400; c_wr_data = wdata_of(32'h400);
        @(negedge clk);
        c_wr_addr = 32'h420; c_wr_data = wdata_of(32'h420);
        @(negedge clk);
        c_wr_addr = 32'h440; c_wr_data = wdata_of(32'h440);
        @(negedge clk);
        c_wr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_count", wb_count, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_empty", wb_empty, 1);
        check("mid_rst_count", wb_count, 0);
        check("mid_rst_wr_ready", c_wr_ready, 1);
        check("mid_rst_m_write", m_write, 0);
        rst_n = 1'b1;
        n0 = log_q.size();
        check("mid_rst_log_size", n0, 1);
        repeat (30) @(negedge clk);
        check("post_rst_no_write", log_q.size(), n0);
        check("post_rst_empty", wb_empty, 1);
        c_wr_valid = 1'b1; c_wr_addr = 32'h460; c_wr_data = wdata_of(32'h460);
        wait_idle();
        check("post_rst_new_write", log_q.size(), n0 + 1);
        if (log_q.size() >= 1) begin
            check("post_rst_new_addr", log_q[log_q.size()-1].addr, 32'h460);
            check("post_rst_new_data", log_q[log_q.size()-1].data, wdata_of(32'h460));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
